// File: rtl/mmio_io_pkg.sv
// Shared definitions for the memory-mapped IO block: register offsets,
// CTRL bit positions and the CTRL register layout.
package mmio_io_pkg;

  // Word offsets within the IO window (addr[7:2]); byte offsets are 4x these.
  localparam logic [5:0] OFS_CTRL    = 6'h00;  // byte 0x00
  localparam logic [5:0] OFS_LEDR    = 6'h01;  // byte 0x04
  localparam logic [5:0] OFS_HEX     = 6'h02;  // byte 0x08
  localparam logic [5:0] OFS_SW      = 6'h03;  // byte 0x0C
  localparam logic [5:0] OFS_SW_EDGE = 6'h04;  // byte 0x10
  localparam logic [5:0] OFS_TCNT    = 6'h05;  // byte 0x14
  localparam logic [5:0] OFS_TCMP    = 6'h06;  // byte 0x18
  localparam logic [5:0] OFS_STATUS  = 6'h07;  // byte 0x1C

  // CTRL bit positions.
  localparam int CTRL_TMR_EN      = 0;
  localparam int CTRL_IRQ_EN      = 1;
  localparam int CTRL_AUTO_RELOAD = 2;
  localparam int CTRL_SW_IRQ_EN   = 3;
  localparam int CTRL_W           = 4;

  // CTRL register layout; the last field is bit 0.
  typedef struct packed {
    logic sw_irq_en;    // bit 3
    logic auto_reload;  // bit 2
    logic irq_en;       // bit 1
    logic tmr_en;       // bit 0
  } ctrl_t;

  // Extract the CTRL fields from a store word.
  function automatic ctrl_t to_ctrl(input logic [31:0] d);
    return ctrl_t'(d[CTRL_W-1:0]);
  endfunction

endpackage

// File: rtl/io_timer.sv
// Prescaled timer: prescaler, TCNT counter, TCMP compare register and the
// sticky match flag. Software writes to TCNT take priority over a tick.
module io_timer
  import mmio_io_pkg::*;
#(
  parameter int TIMER_W  = 32,
  parameter int PRESCALE = 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               tcnt_we,
  input  logic               tcmp_we,
  input  logic               status_we,
  input  logic [TIMER_W-1:0] writedata,
  input  logic               status_clr,
  input  logic               tmr_en,
  input  logic               auto_reload,
  output logic [TIMER_W-1:0] tcnt,
  output logic [TIMER_W-1:0] tcmp,
  output logic               match
);

  localparam int PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE - 1);

  logic [PS_W-1:0] presc;
  logic            tick;
  logic            hit;

  // A tick is the last count of the prescaler period while enabled.
  assign tick = tmr_en && (presc == PS_LAST);
  // Compare always looks at the pre-write counter value.
  assign hit  = (tcnt == tcmp);

  // Prescaler: counts 0..PRESCALE-1 while enabled, holds otherwise.
  always_ff @(posedge clk) begin
    if (reset) begin
      presc <= '0;
    end else if (tmr_en) begin
      presc <= (presc == PS_LAST) ? '0 : presc + PS_W'(1);
    end
  end

  // Counter: a software write wins over the tick update in the same cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      tcnt <= '0;
    end else if (tcnt_we) begin
      tcnt <= writedata;
    end else if (tick) begin
      tcnt <= (hit && auto_reload) ? '0 : tcnt + TIMER_W'(1);
    end
  end

  // Compare register resets to all-ones so an idle timer never matches early.
  always_ff @(posedge clk) begin
    if (reset) begin
      tcmp <= '1;
    end else if (tcmp_we) begin
      tcmp <= writedata;
    end
  end

  // Match flag is write-1-to-clear; a new match in the same cycle wins.
  always_ff @(posedge clk) begin
    if (reset) begin
      match <= 1'b0;
    end else begin
      match <= (match & ~(status_we & status_clr)) | (tick & hit);
    end
  end

endmodule

// File: rtl/mmio_io_ctrl.sv
// IO window peripheral on the core data bus: address decode, LED/HEX output
// registers, synchronised switches with sticky rising-edge flags, a timer
// with compare, and a registered level interrupt.
module mmio_io_ctrl
  import mmio_io_pkg::*;
#(
  parameter int IO_BASE_BIT = 8,
  parameter int LED_W       = 10,
  parameter int HEX_W       = 24,
  parameter int SW_W        = 10,
  parameter int TIMER_W     = 32,
  parameter int PRESCALE    = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      addr,
  input  logic [31:0]      writedata,
  input  logic             memwrite,
  input  logic [SW_W-1:0]  sw,
  output logic             is_io,
  output logic [31:0]      rdata,
  output logic [LED_W-1:0] ledr,
  output logic [HEX_W-1:0] hex_digits,
  output logic             irq
);

  logic [5:0]         offset;
  logic               wr_en;
  logic               ctrl_we;
  logic               ledr_we;
  logic               hex_we;
  logic               edge_we;
  logic               tcnt_we;
  logic               tcmp_we;
  logic               status_we;

  ctrl_t              ctrl;

  logic [SW_W-1:0]    sw_meta;
  logic [SW_W-1:0]    sw_sync;
  logic [SW_W-1:0]    sw_prev;
  logic [SW_W-1:0]    sw_rise;
  logic [SW_W-1:0]    sw_edge;
  logic [SW_W-1:0]    edge_clr;

  logic [TIMER_W-1:0] tcnt;
  logic [TIMER_W-1:0] tcmp;
  logic               match;

  // Address bits outside the decoded fields are intentionally ignored.
  logic               unused_addr;
  assign unused_addr = ^{addr[31:IO_BASE_BIT+1], addr[1:0]};

  // Decode: IO window is a single address bit, registers are word-indexed.
  assign is_io     = addr[IO_BASE_BIT];
  assign offset    = addr[7:2];
  assign wr_en     = memwrite & is_io;
  assign ctrl_we   = wr_en && (offset == OFS_CTRL);
  assign ledr_we   = wr_en && (offset == OFS_LEDR);
  assign hex_we    = wr_en && (offset == OFS_HEX);
  assign edge_we   = wr_en && (offset == OFS_SW_EDGE);
  assign tcnt_we   = wr_en && (offset == OFS_TCNT);
  assign tcmp_we   = wr_en && (offset == OFS_TCMP);
  assign status_we = wr_en && (offset == OFS_STATUS);

  // Plain read/write registers: CTRL, LEDR, HEX.
  always_ff @(posedge clk) begin
    if (reset) begin
      ctrl       <= '0;
      ledr       <= '0;
      hex_digits <= '0;
    end else begin
      if (ctrl_we) ctrl       <= to_ctrl(writedata);
      if (ledr_we) ledr       <= writedata[LED_W-1:0];
      if (hex_we)  hex_digits <= writedata[HEX_W-1:0];
    end
  end

  // Two-flop synchroniser plus a previous-value flop for edge detection.
  always_ff @(posedge clk) begin
    if (reset) begin
      sw_meta <= '0;
      sw_sync <= '0;
      sw_prev <= '0;
    end else begin
      sw_meta <= sw;
      sw_sync <= sw_meta;
      sw_prev <= sw_sync;
    end
  end

  assign sw_rise  = sw_sync & ~sw_prev;
  assign edge_clr = edge_we ? writedata[SW_W-1:0] : '0;

  // Sticky rising-edge flags, write-1-to-clear; a new edge beats a clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      sw_edge <= '0;
    end else begin
      sw_edge <= (sw_edge & ~edge_clr) | sw_rise;
    end
  end

  // Registered level interrupt from the timer match and the switch edges.
  always_ff @(posedge clk) begin
    if (reset) begin
      irq <= 1'b0;
    end else begin
      irq <= (ctrl.irq_en & match) | (ctrl.sw_irq_en & (|sw_edge));
    end
  end

  io_timer #(
    .TIMER_W  (TIMER_W),
    .PRESCALE (PRESCALE)
  ) u_timer (
    .clk         (clk),
    .reset       (reset),
    .tcnt_we     (tcnt_we),
    .tcmp_we     (tcmp_we),
    .status_we   (status_we),
    .writedata   (writedata[TIMER_W-1:0]),
    .status_clr  (writedata[0]),
    .tmr_en      (ctrl.tmr_en),
    .auto_reload (ctrl.auto_reload),
    .tcnt        (tcnt),
    .tcmp        (tcmp),
    .match       (match)
  );

  // Combinational read mux; unmapped offsets and non-IO addresses read 0.
  always_comb begin
    rdata = '0;
    if (is_io) begin
      case (offset)
        OFS_CTRL:    rdata = 32'(ctrl);
        OFS_LEDR:    rdata = 32'(ledr);
        OFS_HEX:     rdata = 32'(hex_digits);
        OFS_SW:      rdata = 32'(sw_sync);
        OFS_SW_EDGE: rdata = 32'(sw_edge);
        OFS_TCNT:    rdata = 32'(tcnt);
        OFS_TCMP:    rdata = 32'(tcmp);
        OFS_STATUS:  rdata = 32'(match);
        default:     rdata = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_mmio_io_ctrl.sv
// Bench for mmio_io_ctrl: a register table, hand sequences for the switch,
// timer and reset corners, and random traffic against a register-map model.
module tb_mmio_io_ctrl;

  localparam int SW_W  = 10;
  localparam int LED_W = 10;
  localparam int HEX_W = 24;
  localparam int PRESCALE_M = 1;  // prescale of the randomly driven instance

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic [31:0]      addr = '0;
  logic [31:0]      writedata = '0;
  logic             memwrite = 1'b0;
  logic [SW_W-1:0]  sw = '0;

  logic             is_io, is_io4;
  logic [31:0]      rdata, rdata4;
  logic [LED_W-1:0] ledr, ledr4;
  logic [HEX_W-1:0] hex_digits, hex4;
  logic             irq, irq4;

  int n_tests = 0;
  int n_fail  = 0;

  mmio_io_ctrl u_dut (
    .clk(clk), .reset(reset), .addr(addr), .writedata(writedata),
    .memwrite(memwrite), .sw(sw), .is_io(is_io), .rdata(rdata),
    .ledr(ledr), .hex_digits(hex_digits), .irq(irq)
  );

  mmio_io_ctrl #(.PRESCALE(4)) u_dut4 (
    .clk(clk), .reset(reset), .addr(addr), .writedata(writedata),
    .memwrite(memwrite), .sw(sw), .is_io(is_io4), .rdata(rdata4),
    .ledr(ledr4), .hex_digits(hex4), .irq(irq4)
  );

  initial begin
    #400000;
    $display("FAIL watchdog: time limit reached, got no finish, required finish");
    $fatal(1);
  end

  // ---------------- driver tasks ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h required 0x%08h", name, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    memwrite = 1'b0;
    cyc(2);
    reset = 1'b0;
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    addr = a; writedata = d; memwrite = 1'b1;
    @(posedge clk);
    #1;
    memwrite = 1'b0;
  endtask

  task automatic bus_read(input string name, input logic [31:0] a, input logic [31:0] exp);
    addr = a; memwrite = 1'b0;
    #1;
    chk(name, rdata, exp);
  endtask

  task automatic bus_read4(input string name, input logic [31:0] a, input logic [31:0] exp);
    addr = a; memwrite = 1'b0;
    #1;
    chk(name, rdata4, exp);
  endtask

  // ---------------- reference model (register-map view) ----------------
  logic [31:0]     m_reg[8];
  logic [31:0]     m_mask[8];
  logic [SW_W-1:0] sw_q[$];     // [0] newest sample, [1] visible SW, [2] older
  int              m_phase;
  logic [34:0]     exp_q[$];    // {irq, hex, ledr} after each edge

  task automatic model_reset();
    for (int i = 0; i < 8; i++) m_reg[i] = '0;
    m_reg[6] = 32'hFFFF_FFFF;
    m_mask = '{32'hF, 32'h3FF, 32'hFF_FFFF, 32'h0, 32'h3FF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h1};
    sw_q = {10'h0, 10'h0, 10'h0};
    m_phase = 0;
    exp_q = {};
  endtask

  function automatic logic [31:0] model_rdata(input logic [31:0] a);
    int ofs;
    ofs = int'(a[7:2]);
    if (!a[8] || ofs > 7) return 32'h0;
    if (ofs == 3) return 32'(sw_q[1]);
    return m_reg[ofs];
  endfunction

  task automatic model_step(input logic [31:0] a, input logic [31:0] d,
                            input logic we, input logic [SW_W-1:0] swv);
    logic [31:0] nx[8];
    logic [31:0] rise;
    int ofs;
    bit wr, tick, hit, nirq;
    nx = m_reg;
    ofs = int'(a[7:2]);
    wr = we && a[8];
    rise = 32'(sw_q[1] & ~sw_q[2]);
    nirq = (m_reg[0][1] && m_reg[7][0]) || (m_reg[0][3] && m_reg[4] != 0);
    tick = m_reg[0][0] && (m_phase == PRESCALE_M - 1);
    if (m_reg[0][0]) m_phase = (m_phase + 1) % PRESCALE_M;
    hit = tick && (m_reg[5] == m_reg[6]);
    if (tick) nx[5] = (hit && m_reg[0][2]) ? 32'h0 : m_reg[5] + 32'h1;
    if (wr) begin
      case (ofs)
        0, 1, 2, 5, 6: nx[ofs] = d & m_mask[ofs];
        default: ;
      endcase
    end
    nx[4] = ((m_reg[4] & ~((wr && ofs == 4) ? d : 32'h0)) | rise) & 32'h3FF;
    nx[7] = (m_reg[7] & ~((wr && ofs == 7) ? (d & 32'h1) : 32'h0)) | (hit ? 32'h1 : 32'h0);
    m_reg = nx;
    sw_q.push_front(swv);
    void'(sw_q.pop_back());
    exp_q.push_back({nirq, m_reg[2][23:0], m_reg[1][9:0]});
  endtask

  // ---------------- register table ----------------
  typedef struct {
    logic        wr;
    logic [31:0] waddr;
    logic [31:0] wdata;
    logic [31:0] raddr;
    logic [31:0] exp_rdata;
    logic        exp_io;
  } vec_t;

  vec_t vecs[20];

  function automatic vec_t mkv(input logic wr, input logic [31:0] wa, input logic [31:0] wd,
                               input logic [31:0] ra, input logic [31:0] er, input logic eio);
    vec_t v;
    v.wr = wr; v.waddr = wa; v.wdata = wd; v.raddr = ra; v.exp_rdata = er; v.exp_io = eio;
    return v;
  endfunction

  // ---------------- test sequence ----------------
  initial begin
    logic [31:0] a, d;
    logic        we;
    logic [34:0] e;
    int          k;

    vecs[0]  = mkv(0, 0, 0, 32'h100, 32'h0, 1);
    vecs[1]  = mkv(0, 0, 0, 32'h104, 32'h0, 1);
    vecs[2]  = mkv(0, 0, 0, 32'h108, 32'h0, 1);
    vecs[3]  = mkv(0, 0, 0, 32'h10C, 32'h0, 1);
    vecs[4]  = mkv(0, 0, 0, 32'h110, 32'h0, 1);
    vecs[5]  = mkv(0, 0, 0, 32'h114, 32'h0, 1);
    vecs[6]  = mkv(0, 0, 0, 32'h118, 32'hFFFF_FFFF, 1);
    vecs[7]  = mkv(0, 0, 0, 32'h11C, 32'h0, 1);
    vecs[8]  = mkv(1, 32'h104, 32'h0000_03FF, 32'h104, 32'h0000_03FF, 1);
    vecs[9]  = mkv(1, 32'h108, 32'h00AB_CDEF, 32'h108, 32'h00AB_CDEF, 1);
    vecs[10] = mkv(1, 32'h104, 32'hFFFF_FFFF, 32'h104, 32'h0000_03FF, 1);
    vecs[11] = mkv(1, 32'h10C, 32'h0000_0123, 32'h10C, 32'h0, 1);
    vecs[12] = mkv(1, 32'h118, 32'h0000_0055, 32'h118, 32'h0000_0055, 1);
    vecs[13] = mkv(1, 32'h100, 32'h0000_00F6, 32'h100, 32'h0000_0006, 1);
    vecs[14] = mkv(1, 32'h120, 32'h0000_DEAD, 32'h120, 32'h0, 1);
    vecs[15] = mkv(1, 32'h004, 32'h0000_0000, 32'h104, 32'h0000_03FF, 1);
    vecs[16] = mkv(1, 32'h0FC, 32'h0000_0000, 32'h0FC, 32'h0, 0);
    vecs[17] = mkv(1, 32'h1FC, 32'h0000_0077, 32'h118, 32'h0000_0055, 1);
    vecs[18] = mkv(1, 32'h11C, 32'h0000_0001, 32'h11C, 32'h0, 1);
    vecs[19] = mkv(1, 32'h100, 32'h0000_0000, 32'h100, 32'h0, 1);

    do_reset();
    chk("rst_ledr", 32'(ledr), 32'h0);
    chk("rst_hex", 32'(hex_digits), 32'h0);
    chk("rst_irq", 32'(irq), 32'h0);

    for (int i = 0; i < 20; i++) begin
      if (vecs[i].wr) begin
        addr = vecs[i].waddr; writedata = vecs[i].wdata; memwrite = 1'b1;
        #1;
        // The RAM write enable is memwrite & !is_io, so IO stores must see is_io=1.
        chk($sformatf("vec%0d_ram_gate", i), 32'(is_io), 32'(vecs[i].waddr[8]));
        @(posedge clk);
        #1;
        memwrite = 1'b0;
      end
      bus_read($sformatf("vec%0d_rdata", i), vecs[i].raddr, vecs[i].exp_rdata);
      chk($sformatf("vec%0d_is_io", i), 32'(is_io), 32'(vecs[i].exp_io));
    end
    chk("tbl_ledr", 32'(ledr), 32'h3FF);
    chk("tbl_hex", 32'(hex_digits), 32'hAB_CDEF);

    // Switch latency and sticky edges.
    sw = 10'h005;
    cyc(1); bus_read("sw_lat1", 32'h10C, 32'h0);
    cyc(1); bus_read("sw_lat2", 32'h10C, 32'h5);
    bus_read("edge_lat2", 32'h110, 32'h0);
    cyc(1); bus_read("edge_set", 32'h110, 32'h5);
    bus_write(32'h110, 32'h1);
    bus_read("edge_w1c", 32'h110, 32'h4);
    sw = 10'h004;
    cyc(3); bus_read("edge_fall_hold", 32'h110, 32'h4);
    sw = 10'h005;
    cyc(2);
    bus_write(32'h110, 32'h1);  // edge on bit0 arrives at this same edge
    bus_read("edge_set_wins", 32'h110, 32'h5);
    bus_write(32'h110, 32'h1);
    bus_read("edge_clear_after", 32'h110, 32'h4);
    chk("swirq_off", 32'(irq), 32'h0);
    bus_write(32'h100, 32'h8);
    chk("swirq_lat0", 32'(irq), 32'h0);
    cyc(1); chk("swirq_lat1", 32'(irq), 32'h1);
    bus_write(32'h110, 32'h3FF);
    chk("swirq_drop0", 32'(irq), 32'h1);
    cyc(1); chk("swirq_drop1", 32'(irq), 32'h0);
    bus_write(32'h100, 32'h0);

    // Timer with auto-reload and interrupt, PRESCALE=1.
    sw = '0;
    do_reset();
    bus_write(32'h118, 32'h4);
    bus_write(32'h100, 32'h7);
    bus_read("tmr_e0", 32'h114, 32'h0);
    cyc(1); bus_read("tmr_e1", 32'h114, 32'h1);
    cyc(3); bus_read("tmr_e4", 32'h114, 32'h4);
    bus_read("tmr_e4_status", 32'h11C, 32'h0);
    cyc(1); bus_read("tmr_e5_reload", 32'h114, 32'h0);
    bus_read("tmr_e5_status", 32'h11C, 32'h1);
    chk("tmr_e5_irq", 32'(irq), 32'h0);
    cyc(1); chk("tmr_e6_irq", 32'(irq), 32'h1);
    bus_read("tmr_e6", 32'h114, 32'h1);
    bus_write(32'h11C, 32'h1);
    chk("tmr_e7_irq", 32'(irq), 32'h1);
    bus_read("tmr_e7_status", 32'h11C, 32'h0);
    cyc(1); chk("tmr_e8_irq", 32'(irq), 32'h0);
    bus_read("tmr_e8", 32'h114, 32'h3);
    bus_write(32'h100, 32'h0);
    bus_read("tmr_e9", 32'h114, 32'h4);
    cyc(3); bus_read("tmr_hold", 32'h114, 32'h4);
    bus_read("tmr_hold_status", 32'h11C, 32'h0);

    // Wrap without auto-reload.
    bus_write(32'h118, 32'h0);
    bus_write(32'h114, 32'hFFFF_FFFE);
    bus_write(32'h100, 32'h1);
    bus_read("wrap_f0", 32'h114, 32'hFFFF_FFFE);
    cyc(1); bus_read("wrap_f1", 32'h114, 32'hFFFF_FFFF);
    cyc(1); bus_read("wrap_f2", 32'h114, 32'h0);
    bus_read("wrap_f2_status", 32'h11C, 32'h0);
    cyc(1); bus_read("wrap_f3_status", 32'h11C, 32'h1);
    bus_read("wrap_f3", 32'h114, 32'h1);
    cyc(1); chk("wrap_irq_dis", 32'(irq), 32'h0);

    // PRESCALE=4 instance.
    do_reset();
    bus_write(32'h100, 32'h1);
    bus_read4("p4_g0", 32'h114, 32'h0);
    cyc(3); bus_read4("p4_g3", 32'h114, 32'h0);
    cyc(1); bus_read4("p4_g4", 32'h114, 32'h1);
    cyc(3); bus_read4("p4_g7", 32'h114, 32'h1);
    cyc(1); bus_read4("p4_g8", 32'h114, 32'h2);
    cyc(3); bus_read4("p4_g11", 32'h114, 32'h2);
    bus_write(32'h114, 32'h50);  // lands on the tick edge
    bus_read4("p4_wr_on_tick", 32'h114, 32'h50);
    cyc(3); bus_read4("p4_g15", 32'h114, 32'h50);
    cyc(1); bus_read4("p4_g16", 32'h114, 32'h51);

    // Reset in the middle of counting.
    bus_write(32'h104, 32'h155);
    bus_write(32'h108, 32'h123456);
    bus_write(32'h118, 32'h2);
    bus_write(32'h114, 32'h0);
    bus_write(32'h100, 32'hF);
    cyc(3);
    chk("pre_rst_irq", 32'(irq), 32'h1);
    chk("pre_rst_ledr", 32'(ledr), 32'h155);
    reset = 1'b1;
    cyc(1);
    chk("mid_rst_ledr", 32'(ledr), 32'h0);
    chk("mid_rst_hex", 32'(hex_digits), 32'h0);
    chk("mid_rst_irq", 32'(irq), 32'h0);
    chk("mid_rst_ledr4", 32'(ledr4), 32'h0);
    chk("mid_rst_hex4", 32'(hex4), 32'h0);
    bus_read("mid_rst_ctrl", 32'h100, 32'h0);
    bus_read("mid_rst_tcnt", 32'h114, 32'h0);
    bus_read("mid_rst_tcmp", 32'h118, 32'hFFFF_FFFF);
    cyc(1);
    bus_read("mid_rst_status", 32'h11C, 32'h0);
    bus_read4("mid_rst_tcnt4", 32'h114, 32'h0);
    reset = 1'b0;

    // Random traffic against the model.
    sw = '0;
    do_reset();
    model_reset();
    for (int i = 0; i < 400; i++) begin
      k = int'($urandom_range(0, 11));
      if (k <= 8) a = 32'h100 + 32'(k) * 4;
      else if (k == 9) a = 32'h100 | (32'($urandom_range(8, 63)) << 2);
      else if (k == 10) a = $urandom & 32'hFFFF_FEFF;
      else a = 32'h100 | ($urandom & 32'hFFFF_FE00) | (32'($urandom_range(0, 7)) << 2)
               | 32'($urandom_range(0, 3));
      if (a[8] && (a[7:2] == 6'd5 || a[7:2] == 6'd6)) d = 32'($urandom_range(0, 12));
      else d = $urandom;
      we = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 7) == 0) sw = SW_W'($urandom_range(0, 1023));
      addr = a; writedata = d; memwrite = we;
      #1;
      chk("rnd_rdata", rdata, model_rdata(a));
      chk("rnd_is_io", 32'(is_io), 32'(a[8]));
      model_step(a, d, we, sw);
      @(posedge clk);
      #1;
      if (exp_q.size() == 0) begin
        chk("rnd_queue", 32'h0, 32'h1);
      end else begin
        e = exp_q.pop_front();
        chk("rnd_ledr", 32'(ledr), 32'(e[9:0]));
        chk("rnd_hex", 32'(hex_digits), 32'(e[33:10]));
        chk("rnd_irq", 32'(irq), 32'(e[34]));
      end
    end
    memwrite = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mmio_io_ctrl.md
Name: mmio_io_ctrl

Overview:
- Memory-mapped I/O peripheral for the single-cycle RISC-V core. It replaces the ad-hoc LEDR/HEX write decode with a single block.
- Address-decodes the IO window and holds parametrised LED and HEX output registers. Also provides a synchronised switch input with sticky edge capture, plus a prescaled timer with compare and interrupt.
- Sits beside the data RAM on the core's data bus; the top-level uses is_io to gate RAM writes and to mux read data.

Parameters:
- IO_BASE_BIT, 8, address bit that selects the IO window (0x0000_0100).
- LED_W, 10, LED output register width.
- HEX_W, 24, HEX digit register width (6 nibbles).
- SW_W, 10, switch input width.
- TIMER_W, 32, timer counter/compare width (≤32).
- PRESCALE, 1, timer tick every PRESCALE clocks (≥1).

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- addr  in  32  data address from core
- writedata  in  32  store data from core
- memwrite  in  1  store strobe from core
- sw  in  SW_W  asynchronous switch inputs
- is_io  out  1  addr[IO_BASE_BIT]; combinational
- rdata  out  32  read data for IO window; combinational
- ledr  out  LED_W  LED register
- hex_digits  out  HEX_W  HEX register
- irq  out  1  level interrupt

Behaviour:
- Register map, offset = addr[7:2], decoded exactly. Unmapped offsets read 0; writes to them are ignored.
  - 0x00 CTRL (RW): bit0 tmr_en, bit1 irq_en, bit2 auto_reload, bit3 sw_irq_en.
  - 0x04 LEDR (RW).
  - 0x08 HEX (RW).
  - 0x0C SW (RO): synchronised switch value.
  - 0x10 SW_EDGE (W1C): sticky rising-edge flags.
  - 0x14 TCNT (RW).
  - 0x18 TCMP (RW).
  - 0x1C STATUS (W1C): bit0 match.
- Write: when memwrite & is_io & offset match, the register updates at the next posedge clk. Narrower registers take writedata LSBs.
- Read: rdata is combinational from current register state and zero-extended. It is 0 when !is_io.
- Reset (sync): ledr=0, hex_digits=0, CTRL=0, TCNT=0, TCMP=all-ones, SW_EDGE=0, match=0, prescaler=0, sync flops=0, irq=0.
- Switch path:
  - Two-flop synchroniser on sw, then a third "previous" flop.
  - SW reads the second sync stage, giving 2-cycle latency from sw change to SW visibility.
  - An edge flag bit sets when sync=1 and prev=0, one cycle after SW shows the change.
- W1C rule: writing a 1 clears that bit; writing 0 leaves it unchanged. If a set and a clear hit the same bit in the same cycle, set wins.
- Prescaler: counts 0..PRESCALE-1 while tmr_en=1 and emits tick at PRESCALE-1. It holds its value when tmr_en=0. When PRESCALE=1, tick occurs every cycle.
- Timer, on tick:
  - If TCNT==TCMP: match sets. TCNT becomes 0 if auto_reload, else TCNT+1.
  - Otherwise TCNT becomes TCNT+1, wrapping mod 2^TIMER_W.
- Priority: a software write to TCNT in the same cycle overrides the tick update. A match evaluated that cycle still uses the pre-write TCNT.
- irq = (irq_en & match) | (sw_irq_en & |SW_EDGE). It is registered, so it asserts 1 cycle after the flag sets and drops 1 cycle after the flag clears.
- A reset asserted mid-count returns all state to reset values in the same edge.

Decomposition:
- Package mmio_io_pkg:
  - offset localparams OFS_CTRL..OFS_STATUS;
  - CTRL bit index constants;
  - a typedef for ctrl_t (packed struct).
- One sub-module, io_timer: prescaler, TCNT, TCMP, match and auto-reload. It takes write strobes, writedata and CTRL bits, and outputs tcnt, tcmp and match.
- The switch sync/edge logic and the decode stay in the top module.

Test Plan:
- Reset, then store 0x3FF to 0x104 and 0x00ABCDEF to 0x108 → ledr=0x3FF and hex_digits=0xABCDEF one edge later. Reading 0x104 returns 0x000003FF. RAM write enable is never asserted.
- sw 0→0x005 → SW reads 0x005 exactly 2 clocks later and SW_EDGE=0x005 one clock after that. Write 0x001 to 0x110 → SW_EDGE=0x004. A new rising edge on bit0 in the same cycle as its clear leaves bit0=1.
- PRESCALE=1, TCMP=4, CTRL=0x7 → match sets on the tick where TCNT==4, TCNT goes to 0, and irq=1 one cycle later. Write 1 to 0x11C → irq drops one cycle later.
- auto_reload=0, TCNT=0xFFFFFFFE, TCMP=0 → TCNT wraps to 0 after 2 ticks, and match sets on the following tick.
- PRESCALE=4 build: TCNT increments once per 4 clocks. A TCNT write on a tick cycle loads the written value, with no increment applied.
- Read 0x120 and 0x0FC → rdata=0, is_io=1 and 0 respectively. Write to 0x120 changes no register. Assert reset mid-count → all outputs return to reset values at the next edge.
